// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between the memory stage and writeback.
// in_ready comes from registered state only, so upstream sees no combinational path from out_ready.
module pipe_skid_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wr_en,
    input  logic              in_mem_read,
    input  logic              in_halt,
    input  logic              in_err,
    input  logic [SEL_W-1:0]  in_wr_sel,
    input  logic [DATA_W-1:0] in_alu_data,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wr_en,
    output logic              out_halt,
    output logic              out_err,
    output logic [SEL_W-1:0]  out_wr_sel,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              sticky_halt,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              wr_en;
        logic              mem_read;
        logic              halt;
        logic              err;
        logic [SEL_W-1:0]  wr_sel;
        logic [DATA_W-1:0] alu_data;
        logic [DATA_W-1:0] mem_data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q;
    entry_t head_q;
    entry_t skid_q;
    logic   sticky_q;
    entry_t in_entry;
    logic   accept;
    logic   emit;

    assign in_entry = '{wr_en:    in_wr_en,
                        mem_read: in_mem_read,
                        halt:     in_halt,
                        err:      in_err,
                        wr_sel:   in_wr_sel,
                        alu_data: in_alu_data,
                        mem_data: in_mem_data};

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO) && !sticky_q;
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // Head fields go out only while an entry is present; otherwise the bus reads as zero.
    assign out_wr_en   = head_q.wr_en && out_valid;
    assign out_halt    = head_q.halt && out_valid;
    assign out_err     = head_q.err && out_valid;
    assign out_wr_sel  = out_valid ? head_q.wr_sel : '0;
    assign out_wb_data = !out_valid      ? '0 :
                         head_q.mem_read ? head_q.mem_data : head_q.alu_data;
    assign sticky_halt = sticky_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // State, storage and sticky halt; flush never clears sticky_q and discards this cycle's emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            head_q   <= '0;
            skid_q   <= '0;
            sticky_q <= 1'b0;
        end else if (flush) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            if (emit && head_q.halt) begin
                sticky_q <= 1'b1;
            end
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q  <= in_entry;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        head_q <= in_entry;
                    end else if (accept) begin
                        skid_q  <= in_entry;
                        state_q <= TWO;
                    end else if (emit) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        head_q  <= skid_q;
                        skid_q  <= '0;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    head_q  <= '0;
                    skid_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a queue model of the two-deep buffer, plus a 32/5-bit instance.
module tb_pipe_skid_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_ready, out_valid;
    logic        in_wr_en, in_mem_read, in_halt, in_err;
    logic [2:0]  in_wr_sel, out_wr_sel;
    logic [15:0] in_alu_data, in_mem_data, out_wb_data;
    logic        out_wr_en, out_halt, out_err, sticky_halt;
    logic [1:0]  occupancy;

    logic        in_valid2, in_ready2, out_valid2;
    logic [4:0]  in_wr_sel2, out_wr_sel2;
    logic [31:0] in_alu_data2, out_wb_data2;
    logic        out_wr_en2, out_halt2, out_err2, sticky_halt2;
    logic [1:0]  occupancy2;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wr_en(in_wr_en), .in_mem_read(in_mem_read), .in_halt(in_halt), .in_err(in_err),
        .in_wr_sel(in_wr_sel), .in_alu_data(in_alu_data), .in_mem_data(in_mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wr_en(out_wr_en), .out_halt(out_halt), .out_err(out_err),
        .out_wr_sel(out_wr_sel), .out_wb_data(out_wb_data),
        .sticky_halt(sticky_halt), .occupancy(occupancy)
    );

    pipe_skid_stage #(.DATA_W(32), .SEL_W(5)) dut_wide (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_wr_en(1'b1), .in_mem_read(1'b0), .in_halt(1'b0), .in_err(1'b0),
        .in_wr_sel(in_wr_sel2), .in_alu_data(in_alu_data2), .in_mem_data(32'h0),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_wr_en(out_wr_en2), .out_halt(out_halt2), .out_err(out_err2),
        .out_wr_sel(out_wr_sel2), .out_wb_data(out_wb_data2),
        .sticky_halt(sticky_halt2), .occupancy(occupancy2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: entries in acceptance order; what the writeback side must see.
    typedef struct {
        logic [15:0] wb;
        logic [2:0]  sel;
        logic        wr_en;
        logic        halt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    bit   m_sticky = 1'b0;
    bit   live     = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        if (live) begin
            chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2 && !m_sticky));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            chk("sticky_halt", 64'(sticky_halt), 64'(m_sticky));
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                chk("head", 64'({out_wr_en, out_halt, out_err, out_wr_sel, out_wb_data}),
                    64'({e.wr_en, e.halt, e.err, e.sel, e.wb}));
            end else begin
                chk("idle_zero", 64'({out_wr_en, out_halt, out_err, out_wr_sel, out_wb_data}), 64'h0);
            end
        end
        if (rst) begin
            exp_q.delete();
            m_sticky = 1'b0;
            live     = 1'b1;
        end else if (live) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                acc = in_valid && exp_q.size() < 2 && !m_sticky;
                if (out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.halt) m_sticky = 1'b1;
                end
                if (acc) begin
                    e.wb    = in_mem_read ? in_mem_data : in_alu_data;
                    e.sel   = in_wr_sel;
                    e.wr_en = in_wr_en;
                    e.halt  = in_halt;
                    e.err   = in_err;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Wide instance: out_ready tied high, so every accepted word must appear the following cycle.
    logic [36:0] exp2_q[$];
    bit          live2 = 1'b0;

    always @(negedge clk) begin
        if (live2) begin
            chk("wide_occupancy", 64'(occupancy2), 64'(exp2_q.size()));
            if (exp2_q.size() != 0)
                chk("wide_head", 64'({out_wr_sel2, out_wb_data2}), 64'(exp2_q[0]));
            else
                chk("wide_idle_zero", 64'({out_valid2, out_wr_sel2, out_wb_data2}), 64'h0);
        end
        if (rst) begin
            exp2_q.delete();
            live2 = 1'b1;
        end else if (live2) begin
            if (exp2_q.size() != 0) void'(exp2_q.pop_front());
            if (in_valid2 && exp2_q.size() < 2) exp2_q.push_back({in_wr_sel2, in_alu_data2});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [2:0] sel, input logic mr, input logic [15:0] alu,
                       input logic [15:0] mem, input logic h, input logic e);
        in_valid    = 1'b1;
        in_wr_en    = 1'b1;
        in_wr_sel   = sel;
        in_mem_read = mr;
        in_alu_data = alu;
        in_mem_data = mem;
        in_halt     = h;
        in_err      = e;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_wr_en = 1'b0; in_mem_read = 1'b0; in_halt = 1'b0; in_err = 1'b0;
        in_wr_sel = '0; in_alu_data = '0; in_mem_data = '0;
        in_valid2 = 1'b0; in_wr_sel2 = '0; in_alu_data2 = '0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Back-to-back stream on both instances
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            put(3'(i), 1'b0, 16'(i * 'h11), 16'($urandom), 1'b0, 1'b0);
            in_valid2    = 1'b1;
            in_wr_sel2   = 5'd31;
            in_alu_data2 = 32'hDEADBEEF + 32'(i - 1);
            cyc();
        end
        in_valid = 1'b0; in_valid2 = 1'b0;
        repeat (3) cyc();

        // Backpressure: fill both slots, offer a third, then drain
        out_ready = 1'b0;
        put(3'd5, 1'b0, 16'hAAAA, 16'h0F0F, 1'b0, 1'b0); cyc();
        put(3'd6, 1'b1, 16'h1357, 16'hBBBB, 1'b0, 1'b1); cyc();
        put(3'd7, 1'b0, 16'hCCCC, 16'h0000, 1'b0, 1'b0); cyc(); cyc();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();

        // Flush while full, with a new entry and a consume in the same cycle
        out_ready = 1'b0;
        put(3'd1, 1'b0, 16'h0101, 16'h0, 1'b0, 1'b0); cyc();
        put(3'd2, 1'b0, 16'h0202, 16'h0, 1'b0, 1'b0); cyc();
        put(3'd3, 1'b0, 16'h0303, 16'h0, 1'b0, 1'b0);
        flush = 1'b1; out_ready = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) cyc();

        // Reset while full, then one entry must pass through unchanged
        out_ready = 1'b0;
        put(3'd4, 1'b0, 16'h4444, 16'h0, 1'b0, 1'b0); cyc();
        put(3'd5, 1'b1, 16'h0, 16'h5555, 1'b0, 1'b0); cyc();
        in_valid = 1'b0; rst = 1'b1; cyc();
        rst = 1'b0; out_ready = 1'b1;
        put(3'd2, 1'b0, 16'h1234, 16'hFFFF, 1'b0, 1'b0); cyc();
        in_valid = 1'b0;
        repeat (2) cyc();

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            put(3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'($urandom));
            in_wr_en  = 1'($urandom);
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            rst       = ($urandom % 60) == 0;
            cyc();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();

        // Halt delivery locks the input; flush keeps the lock, reset releases it
        put(3'd3, 1'b0, 16'h7777, 16'h0, 1'b1, 1'b0); cyc();
        in_valid = 1'b0; repeat (2) cyc();
        put(3'd4, 1'b0, 16'h8888, 16'h0, 1'b0, 1'b0); repeat (2) cyc();
        in_valid = 1'b0; flush = 1'b1; cyc();
        flush = 1'b0; repeat (2) cyc();
        rst = 1'b1; cyc();
        rst = 1'b0;
        put(3'd6, 1'b1, 16'h0, 16'h9999, 1'b0, 1'b1); cyc();
        in_valid = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
